// File: rtl/rc_tag_scheduler.sv
// Read-tag allocator and RC completion router: round-robin tag grants to NUM_REQ
// requesters, owner tracking per tag, completion routing, and age-based timeout.
module rc_tag_scheduler #(
    parameter  int NUM_REQ     = 2,
    parameter  int NUM_TAGS    = 32,
    parameter  int TICK_SHIFT  = 10,
    parameter  int TIMEOUT_AGE = 12,
    localparam int REQ_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    output logic                rq_valid,
    input  logic                rq_ready,
    output logic [7:0]          rq_tag,
    output logic [REQ_ID_W-1:0] rq_req_id,
    input  logic                rc_desc_valid,
    input  logic [7:0]          rc_tag,
    input  logic [2:0]          rc_status,
    input  logic                rc_request_completed,
    input  logic                rc_valid,
    input  logic                rc_sop,
    input  logic                rc_eop,
    input  logic [255:0]        rc_data,
    input  logic [7:0]          rc_keep,
    output logic                cpl_valid,
    output logic [REQ_ID_W-1:0] cpl_id,
    output logic                cpl_sop,
    output logic                cpl_eop,
    output logic [255:0]        cpl_data,
    output logic [7:0]          cpl_keep,
    output logic                cpl_err,
    output logic                err_unexpected,
    output logic                timeout_valid,
    output logic [7:0]          timeout_tag,
    output logic [REQ_ID_W-1:0] timeout_id,
    output logic [8:0]          tags_free
);

    localparam int TAG_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    typedef logic [3:0] age_t;

    function automatic age_t age_sat_inc(input age_t a);
        return (a == 4'hF) ? a : a + 4'h1;
    endfunction

    logic [NUM_TAGS-1:0]   free_map;
    logic [REQ_ID_W-1:0]   owner [NUM_TAGS];
    age_t                  age   [NUM_TAGS];
    logic [REQ_ID_W-1:0]   rr_ptr;
    logic [TICK_SHIFT-1:0] pre_cnt;
    logic                  age_tick;

    logic                  can_issue;
    logic                  req_found;
    logic                  tag_found;
    logic                  grant;
    logic [REQ_ID_W-1:0]   cand;
    logic [REQ_ID_W-1:0]   gnt_id;
    logic [TAG_W-1:0]      gnt_tag;

    logic [TAG_W-1:0]      desc_idx;
    logic                  desc_in_range;
    logic                  desc_hit;
    logic                  desc_err;
    logic [REQ_ID_W-1:0]   desc_owner;
    logic                  cmp_free;
    logic                  desc_hit_p1;
    logic                  desc_err_p1;
    logic [REQ_ID_W-1:0]   desc_owner_p1;
    logic                  beat_hit;
    logic                  beat_err;
    logic [REQ_ID_W-1:0]   beat_owner;

    logic                  to_found;
    logic                  to_fire;
    logic [TAG_W-1:0]      to_idx;

    assign age_tick = &pre_cnt;

    always_comb begin
        can_issue = !rq_valid || rq_ready;
        req_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = REQ_ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!req_found && req_valid[cand]) begin
                req_found = 1'b1;
                gnt_id    = cand;
            end
        end
        tag_found = 1'b0;
        gnt_tag   = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (free_map[t]) begin
                tag_found = 1'b1;
                gnt_tag   = TAG_W'(t);
            end
        end
        grant     = req_found && tag_found && can_issue;
        req_ready = '0;
        if (grant) req_ready[gnt_id] = 1'b1;
    end

    // Lookup uses the table as it stands this cycle, so a tag freed now still hits.
    always_comb begin
        desc_idx      = rc_tag[TAG_W-1:0];
        desc_in_range = (32'(rc_tag) < NUM_TAGS);
        desc_hit      = rc_desc_valid && desc_in_range && !free_map[desc_idx];
        desc_err      = (rc_status != 3'd0);
        desc_owner    = owner[desc_idx];
        cmp_free      = desc_hit && (rc_request_completed || desc_err);
        beat_hit      = rc_desc_valid ? desc_hit   : desc_hit_p1;
        beat_err      = rc_desc_valid ? desc_err   : desc_err_p1;
        beat_owner    = rc_desc_valid ? desc_owner : desc_owner_p1;
    end

    // Any descriptor hit defers timeouts a cycle, so at most one tag frees per cycle.
    always_comb begin
        to_found = 1'b0;
        to_idx   = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (!free_map[t] && age[t] >= 4'(TIMEOUT_AGE)) begin
                to_found = 1'b1;
                to_idx   = TAG_W'(t);
            end
        end
        to_fire = to_found && !desc_hit;
    end

    always_ff @(posedge clk) begin
        if (grant) owner[gnt_tag] <= gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TAGS; t++) age[t] <= '0;
        end else begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                if ((grant && gnt_tag == TAG_W'(t)) || (desc_hit && desc_idx == TAG_W'(t)))
                    age[t] <= '0;
                else if (age_tick && !free_map[t])
                    age[t] <= age_sat_inc(age[t]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map       <= '1;
            rr_ptr         <= '0;
            pre_cnt        <= '0;
            tags_free      <= 9'(NUM_TAGS);
            rq_valid       <= 1'b0;
            rq_tag         <= '0;
            rq_req_id      <= '0;
            desc_hit_p1    <= 1'b0;
            desc_err_p1    <= 1'b0;
            desc_owner_p1  <= '0;
            cpl_valid      <= 1'b0;
            cpl_id         <= '0;
            cpl_sop        <= 1'b0;
            cpl_eop        <= 1'b0;
            cpl_data       <= '0;
            cpl_keep       <= '0;
            cpl_err        <= 1'b0;
            err_unexpected <= 1'b0;
            timeout_valid  <= 1'b0;
            timeout_tag    <= '0;
            timeout_id     <= '0;
        end else begin
            pre_cnt <= pre_cnt + TICK_SHIFT'(1);

            if (grant) free_map[gnt_tag] <= 1'b0;
            if (cmp_free) free_map[desc_idx] <= 1'b1;
            if (to_fire) free_map[to_idx] <= 1'b1;

            case ({grant, cmp_free || to_fire})
                2'b10:   tags_free <= tags_free - 9'd1;
                2'b01:   tags_free <= tags_free + 9'd1;
                default: tags_free <= tags_free;
            endcase

            // Issue stage: held stable until the RQ path accepts it.
            if (grant) begin
                rq_valid  <= 1'b1;
                rq_tag    <= 8'(gnt_tag);
                rq_req_id <= gnt_id;
                rr_ptr    <= REQ_ID_W'((int'(gnt_id) + 1) % NUM_REQ);
            end else if (rq_ready) begin
                rq_valid  <= 1'b0;
            end

            if (rc_desc_valid) begin
                desc_hit_p1   <= desc_hit;
                desc_err_p1   <= desc_err;
                desc_owner_p1 <= desc_owner;
            end

            // Completion stage: fixed one-cycle latency, misses dropped.
            cpl_valid <= rc_valid && beat_hit;
            if (rc_valid && beat_hit) begin
                cpl_id   <= beat_owner;
                cpl_sop  <= rc_sop;
                cpl_eop  <= rc_eop;
                cpl_data <= rc_data;
                cpl_keep <= rc_keep;
                cpl_err  <= beat_err;
            end
            err_unexpected <= rc_desc_valid && !desc_hit;

            timeout_valid <= to_fire;
            if (to_fire) begin
                timeout_tag <= 8'(to_idx);
                timeout_id  <= owner[to_idx];
            end
        end
    end

endmodule

// File: tb/tb_rc_tag_scheduler.sv
// Directed bench for rc_tag_scheduler: allocation, exhaustion, routing, split and
// error completions, backpressure, timeout and mid-operation reset.
module tb_rc_tag_scheduler;

    localparam int NUM_REQ     = 2;
    localparam int NUM_TAGS    = 32;
    localparam int TICK_SHIFT  = 6;
    localparam int TIMEOUT_AGE = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic         rq_valid;
    logic         rq_ready;
    logic [7:0]   rq_tag;
    logic [0:0]   rq_req_id;
    logic         rc_desc_valid;
    logic [7:0]   rc_tag;
    logic [2:0]   rc_status;
    logic         rc_request_completed;
    logic         rc_valid;
    logic         rc_sop;
    logic         rc_eop;
    logic [255:0] rc_data;
    logic [7:0]   rc_keep;
    logic         cpl_valid;
    logic [0:0]   cpl_id;
    logic         cpl_sop;
    logic         cpl_eop;
    logic [255:0] cpl_data;
    logic [7:0]   cpl_keep;
    logic         cpl_err;
    logic         err_unexpected;
    logic         timeout_valid;
    logic [7:0]   timeout_tag;
    logic [0:0]   timeout_id;
    logic [8:0]   tags_free;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [255:0] bd [3];
    logic [255:0] d;

    rc_tag_scheduler #(
        .NUM_REQ(NUM_REQ), .NUM_TAGS(NUM_TAGS),
        .TICK_SHIFT(TICK_SHIFT), .TIMEOUT_AGE(TIMEOUT_AGE)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_tag(rq_tag), .rq_req_id(rq_req_id),
        .rc_desc_valid(rc_desc_valid), .rc_tag(rc_tag), .rc_status(rc_status),
        .rc_request_completed(rc_request_completed),
        .rc_valid(rc_valid), .rc_sop(rc_sop), .rc_eop(rc_eop),
        .rc_data(rc_data), .rc_keep(rc_keep),
        .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_sop(cpl_sop), .cpl_eop(cpl_eop),
        .cpl_data(cpl_data), .cpl_keep(cpl_keep), .cpl_err(cpl_err),
        .err_unexpected(err_unexpected),
        .timeout_valid(timeout_valid), .timeout_tag(timeout_tag), .timeout_id(timeout_id),
        .tags_free(tags_free)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_rc();
        rc_desc_valid        = 1'b0;
        rc_tag               = '0;
        rc_status            = '0;
        rc_request_completed = 1'b0;
        rc_valid             = 1'b0;
        rc_sop               = 1'b0;
        rc_eop               = 1'b0;
        rc_data              = '0;
        rc_keep              = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rq_ready  = 1'b0;
        idle_rc();
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic drive_desc(input logic [7:0] tag, input logic [2:0] st, input logic done);
        rc_desc_valid        = 1'b1;
        rc_tag               = tag;
        rc_status            = st;
        rc_request_completed = done;
    endtask

    task automatic drive_beat(input logic sop, input logic eop, input logic [255:0] dat,
                              input logic [7:0] keep);
        rc_valid = 1'b1;
        rc_sop   = sop;
        rc_eop   = eop;
        rc_data  = dat;
        rc_keep  = keep;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_tags_free", tags_free, 32);
        chk("rst_rq_valid", rq_valid, 0);
        chk("rst_rq_tag", rq_tag, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cpl_valid", cpl_valid, 0);
        chk("rst_cpl_data", cpl_data, 0);
        chk("rst_err_unexp", err_unexpected, 0);
        chk("rst_timeout", timeout_valid, 0);

        // Round-robin between both requesters.
        req_valid = 2'b11;
        rq_ready  = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_req_ready", req_ready, (k % 2) ? 2 : 1);
            tick();
            chk("rr_rq_valid", rq_valid, 1);
            chk("rr_rq_tag", rq_tag, k);
            chk("rr_rq_req_id", rq_req_id, k % 2);
            chk("rr_tags_free", tags_free, 31 - k);
            if (k == 3) req_valid = '0;
        end
        tick();
        chk("rr_rq_idle", rq_valid, 0);
        chk("rr_tags_free_end", tags_free, 28);

        // Tag 3 (owner 1): descriptor first, then three beats.
        drive_desc(8'd3, 3'd0, 1'b1);
        tick();
        rc_desc_valid = 1'b0;
        chk("rt_err_unexp", err_unexpected, 0);
        chk("rt_cpl_idle", cpl_valid, 0);
        chk("rt_tags_free", tags_free, 29);
        for (int b = 0; b < 3; b++) begin
            bd[b] = rand256();
            drive_beat(b == 0, b == 2, bd[b], (b == 2) ? 8'h0F : 8'hFF);
            tick();
            chk("rt_cpl_valid", cpl_valid, 1);
            chk("rt_cpl_id", cpl_id, 1);
            chk("rt_cpl_sop", cpl_sop, b == 0);
            chk("rt_cpl_eop", cpl_eop, b == 2);
            chk("rt_cpl_data", cpl_data, bd[b]);
            chk("rt_cpl_keep", cpl_keep, (b == 2) ? 8'h0F : 8'hFF);
            chk("rt_cpl_err", cpl_err, 0);
        end
        idle_rc();
        tick();
        chk("rt_cpl_done", cpl_valid, 0);

        // Single-beat packet to tag 2 (owner 0).
        d = rand256();
        drive_desc(8'd2, 3'd0, 1'b1);
        drive_beat(1'b1, 1'b1, d, 8'h03);
        tick();
        idle_rc();
        chk("sb_cpl_valid", cpl_valid, 1);
        chk("sb_cpl_id", cpl_id, 0);
        chk("sb_cpl_data", cpl_data, d);
        chk("sb_cpl_sop_eop", {cpl_sop, cpl_eop}, 2'b11);
        chk("sb_cpl_keep", cpl_keep, 8'h03);
        chk("sb_tags_free", tags_free, 30);

        // Exhaustion from requester 0 only.
        do_reset();
        req_valid = 2'b01;
        rq_ready  = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("ex_rq_tag", rq_tag, k);
        end
        chk("ex_rq_valid", rq_valid, 1);
        chk("ex_tags_free", tags_free, 0);
        chk("ex_req_ready", req_ready, 0);
        tick();
        chk("ex_rq_stall", rq_valid, 0);
        chk("ex_req_ready_stall", req_ready, 0);

        drive_desc(8'd5, 3'd0, 1'b1);
        chk("fr_req_ready_same", req_ready, 0);
        tick();
        idle_rc();
        chk("fr_tags_free", tags_free, 1);
        chk("fr_rq_valid", rq_valid, 0);
        chk("fr_req_ready", req_ready, 2'b01);
        tick();
        chk("fr_regrant_valid", rq_valid, 1);
        chk("fr_regrant_tag", rq_tag, 5);
        chk("fr_tags_free_0", tags_free, 0);
        req_valid = '0;
        tick();

        // Split completion on tag 7.
        d = rand256();
        drive_desc(8'd7, 3'd0, 1'b0);
        drive_beat(1'b1, 1'b1, d, 8'hFF);
        tick();
        chk("sp1_cpl_valid", cpl_valid, 1);
        chk("sp1_cpl_data", cpl_data, d);
        chk("sp1_tags_free", tags_free, 0);
        d = rand256();
        drive_desc(8'd7, 3'd0, 1'b1);
        drive_beat(1'b1, 1'b1, d, 8'hFF);
        tick();
        chk("sp2_cpl_valid", cpl_valid, 1);
        chk("sp2_cpl_data", cpl_data, d);
        chk("sp2_tags_free", tags_free, 1);
        drive_desc(8'd7, 3'd0, 1'b1);
        drive_beat(1'b1, 1'b1, rand256(), 8'hFF);
        tick();
        idle_rc();
        chk("sp3_err_unexp", err_unexpected, 1);
        chk("sp3_cpl_drop", cpl_valid, 0);
        chk("sp3_tags_free", tags_free, 1);
        tick();
        chk("sp3_err_pulse", err_unexpected, 0);

        // Error status on tag 9, two beats.
        drive_desc(8'd9, 3'b001, 1'b0);
        drive_beat(1'b1, 1'b0, rand256(), 8'hFF);
        tick();
        rc_desc_valid = 1'b0;
        chk("er_cpl_valid0", cpl_valid, 1);
        chk("er_cpl_err0", cpl_err, 1);
        chk("er_tags_free", tags_free, 2);
        drive_beat(1'b0, 1'b1, rand256(), 8'hFF);
        tick();
        idle_rc();
        chk("er_cpl_valid1", cpl_valid, 1);
        chk("er_cpl_err1", cpl_err, 1);
        chk("er_cpl_eop1", cpl_eop, 1);

        // Tag beyond NUM_TAGS.
        drive_desc(8'd40, 3'd0, 1'b1);
        drive_beat(1'b1, 1'b1, rand256(), 8'hFF);
        tick();
        idle_rc();
        chk("oor_err_unexp", err_unexpected, 1);
        chk("oor_cpl_drop", cpl_valid, 0);
        chk("oor_tags_free", tags_free, 2);

        // Backpressure from the RQ path.
        do_reset();
        req_valid = 2'b11;
        rq_ready  = 1'b0;
        tick();
        chk("bp_rq_valid", rq_valid, 1);
        chk("bp_rq_tag", rq_tag, 0);
        chk("bp_tags_free", tags_free, 31);
        for (int k = 0; k < 5; k++) begin
            chk("bp_req_ready_hold", req_ready, 0);
            tick();
            chk("bp_rq_valid_hold", rq_valid, 1);
            chk("bp_rq_tag_hold", rq_tag, 0);
            chk("bp_rq_id_hold", rq_req_id, 0);
            chk("bp_tags_free_hold", tags_free, 31);
        end
        rq_ready = 1'b1;
        #1;
        chk("bp_req_ready_rel", req_ready, 2'b10);
        tick();
        req_valid = '0;
        chk("bp_rq_tag_next", rq_tag, 1);
        chk("bp_rq_id_next", rq_req_id, 1);
        chk("bp_tags_free_next", tags_free, 30);
        tick();
        chk("bp_rq_idle", rq_valid, 0);

        // Tags 0 and 1 age out with no completions.
        while (timeout_valid !== 1'b1 && cyc < 400) tick();
        chk("to_seen", timeout_valid, 1);
        chk("to_window", (cyc >= 180 && cyc <= 210), 1);
        chk("to_tag0", timeout_tag, 0);
        chk("to_id0", timeout_id, 0);
        chk("to_tags_free0", tags_free, 31);
        tick();
        chk("to_valid1", timeout_valid, 1);
        chk("to_tag1", timeout_tag, 1);
        chk("to_id1", timeout_id, 1);
        chk("to_tags_free1", tags_free, 32);
        tick();
        chk("to_pulse_end", timeout_valid, 0);

        drive_desc(8'd0, 3'd0, 1'b1);
        drive_beat(1'b1, 1'b1, rand256(), 8'hFF);
        tick();
        idle_rc();
        chk("late_err_unexp", err_unexpected, 1);
        chk("late_cpl_drop", cpl_valid, 0);
        chk("late_tags_free", tags_free, 32);

        // Reset while a tag is outstanding.
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        chk("mr_rq_valid", rq_valid, 1);
        chk("mr_tags_free", tags_free, 31);
        do_reset();
        chk("mr_rst_tags_free", tags_free, 32);
        chk("mr_rst_rq_valid", rq_valid, 0);
        drive_desc(8'd0, 3'd0, 1'b1);
        drive_beat(1'b1, 1'b1, rand256(), 8'hFF);
        tick();
        idle_rc();
        chk("mr_err_unexp", err_unexpected, 1);
        chk("mr_cpl_drop", cpl_valid, 0);
        chk("mr_tags_free_after", tags_free, 32);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
